// File: rtl/apb_req_master.sv
// ---------------------------------------------------------------------------
// apb_req_master
//
// APB requester for the CSR slave bus. A local controller hands over one
// command at a time on a valid/ready port; the block runs it as a
// SETUP -> ACCESS transfer and returns exactly one response pulse carrying
// the read data and error status. A wait-state counter aborts transfers
// whose slave never raises ready.
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   cmd_valid/ready   command handshake; cmd_ready is high only in IDLE
//   cmd_write         1 = write, 0 = read
//   cmd_addr          target address            (ADDRESS_SIZE bits)
//   cmd_wdata         write data                (REG_WIDTH bits)
//   rsp_valid         one-cycle response pulse
//   rsp_rdata         read data (0 for writes and timeouts)
//   rsp_err           slave error or timeout
//   rsp_timeout       transfer aborted by the wait-state timeout
//   addr/sel/en/      APB request outputs, all registered
//   write/wdata
//   ready/slv_err/    APB completion inputs, only looked at in ACCESS
//   rdata
// ---------------------------------------------------------------------------
module apb_req_master #(
    parameter int ADDRESS_SIZE   = 32,
    parameter int REG_WIDTH      = 8,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int TIMEOUT_W      = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,

    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDRESS_SIZE-1:0] cmd_addr,
    input  logic [REG_WIDTH-1:0]    cmd_wdata,

    output logic                    rsp_valid,
    output logic [REG_WIDTH-1:0]    rsp_rdata,
    output logic                    rsp_err,
    output logic                    rsp_timeout,

    output logic [ADDRESS_SIZE-1:0] addr,
    output logic                    sel,
    output logic                    en,
    output logic                    write,
    output logic [REG_WIDTH-1:0]    wdata,
    input  logic                    ready,
    input  logic                    slv_err,
    input  logic [REG_WIDTH-1:0]    rdata
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    // A zero TIMEOUT_CYCLES disables the abort path entirely.
    localparam bit                   TO_EN    = (TIMEOUT_CYCLES != 0);
    localparam logic [TIMEOUT_W-1:0] TERM_CNT =
        TIMEOUT_W'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);

    state_t                  state_q;
    logic [ADDRESS_SIZE-1:0] addr_q;
    logic                    sel_q;
    logic                    en_q;
    logic                    write_q;
    logic [REG_WIDTH-1:0]    wdata_q;
    logic                    rsp_valid_q;
    logic [REG_WIDTH-1:0]    rsp_rdata_q;
    logic                    rsp_err_q;
    logic                    rsp_timeout_q;
    logic [TIMEOUT_W-1:0]    cnt_q;
    logic [TIMEOUT_W-1:0]    cnt_d;
    logic                    timeout_hit;

    // cnt_q holds the number of ready=0 ACCESS cycles already seen, so the
    // terminal compare uses the current value: en stays high for exactly
    // TIMEOUT_CYCLES cycles before the abort.
    assign cnt_d       = cnt_q + TIMEOUT_W'(1);
    assign timeout_hit = TO_EN && (cnt_q == TERM_CNT);

    assign cmd_ready   = (state_q == ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            addr_q        <= '0;
            sel_q         <= 1'b0;
            en_q          <= 1'b0;
            write_q       <= 1'b0;
            wdata_q       <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
            cnt_q         <= '0;
        end else begin
            // Response is a single-cycle pulse; payload fields hold.
            rsp_valid_q <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        addr_q  <= cmd_addr;
                        write_q <= cmd_write;
                        wdata_q <= cmd_wdata;
                        sel_q   <= 1'b1;
                        en_q    <= 1'b0;
                        state_q <= ST_SETUP;
                    end
                end

                ST_SETUP: begin
                    en_q    <= 1'b1;
                    cnt_q   <= '0;
                    state_q <= ST_ACCESS;
                end

                ST_ACCESS: begin
                    // A ready on the terminal-count cycle still completes
                    // normally: ready is tested before the timeout.
                    if (ready) begin
                        sel_q         <= 1'b0;
                        en_q          <= 1'b0;
                        rsp_valid_q   <= 1'b1;
                        rsp_err_q     <= slv_err;
                        rsp_timeout_q <= 1'b0;
                        rsp_rdata_q   <= write_q ? '0 : rdata;
                        state_q       <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_d;
                        if (timeout_hit) begin
                            sel_q         <= 1'b0;
                            en_q          <= 1'b0;
                            rsp_valid_q   <= 1'b1;
                            rsp_err_q     <= 1'b1;
                            rsp_timeout_q <= 1'b1;
                            rsp_rdata_q   <= '0;
                            state_q       <= ST_IDLE;
                        end
                    end
                end

                default: begin
                    sel_q   <= 1'b0;
                    en_q    <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign addr        = addr_q;
    assign sel         = sel_q;
    assign en          = en_q;
    assign write       = write_q;
    assign wdata       = wdata_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_timeout_q;

endmodule
